data_memory_lsu: RTL and testbench
==================================

Name: data_memory_lsu

Overview:
- Parametrised byte-addressable data memory for the RV32 core; next-generation data memory.
- Adds byte/halfword/word accesses per RV32I funct3, with sign or zero extension on loads.
- Adds valid/ready request and response handshakes, a registered read, alignment and range error reporting, and a hardware clear sequence after reset.
- Sits between the execute/memory stage and the write-back mux.

Parameters:
- DEPTH, 256: number of 32-bit words; power of two, minimum 4.
- ADDR_W, 32: request address width in bits (byte address).
- CLEAR_ON_RESET, 1: 1 = zero all words after reset; 0 = skip clearing and keep contents.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_funct3  input  3  access size/sign code, RV32I encoding.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  access faulted (misaligned, out of range, or illegal funct3).
- init_done  output  1  clear sequence finished; stays high until the next reset.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-high; it forces state=CLEAR, clr_ptr=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
- States: CLEAR, IDLE, RESP.
- CLEAR:
  - With CLEAR_ON_RESET=1, writes 0 to word clr_ptr each cycle and increments clr_ptr.
  - After writing word DEPTH-1, goes to IDLE and sets init_done=1. The clear takes exactly DEPTH cycles after reset deasserts.
  - With CLEAR_ON_RESET=0, goes to IDLE on the first clock after reset deasserts, with no writes.
  - req_ready=0 throughout CLEAR.
- Handshake:
  - req_ready = (state==IDLE) | (state==RESP & rsp_ready).
  - A request is accepted on a clock edge where req_valid & req_ready.
  - Accept moves to RESP, or stays in RESP. A RESP with rsp_ready and no new request returns to IDLE.
  - The response is registered: rsp_valid rises the cycle after accept.
  - rsp_rdata and rsp_err hold stable while rsp_valid & !rsp_ready.
  - Back-to-back accepts with rsp_ready held high give one access per cycle.
- Decode:
  - word index = req_addr[log2(DEPTH)+1:2]; lane = req_addr[1:0].
  - Out of range: req_addr >= 4*DEPTH.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code for the access direction is illegal.
  - Misaligned: halfword with lane[0]=1, or word with lane!=0.
- Error: any fault sets rsp_err=1 and rsp_rdata=0, and no memory write occurs.
- Stores:
  - Memory is written at the accept edge, using byte enables built from funct3 and lane.
  - SB writes req_wdata[7:0] to the byte at lane.
  - SH writes req_wdata[15:0] to lanes {lane+1, lane}.
  - The response has rsp_err=0 and rsp_rdata=0.
- Loads:
  - The word is read at the accept edge.
  - The byte or half is selected by lane, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Read-after-write: a load accepted the cycle after a store to the same word returns the stored data; no forwarding is needed because the store completes at its own accept edge.
- Reset mid-operation: any pending response is dropped (rsp_valid=0 immediately) and the CLEAR sequence restarts from word 0.

Test Plan:
- Clear sequence: DEPTH=8, reset pulse -> init_done rises 8 cycles after reset deasserts; LW addr 0x1C -> rdata 0x00000000, err 0.
- Word store/load: SW 0xDEADBEEF @0x10, then LW @0x10 next cycle with rsp_ready=1 -> rsp_rdata 0xDEADBEEF one cycle after the LW accept.
- Byte and half extension:
  - With word 0x10 = 0xDEADBEEF: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
  - SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF.
- Faults, each -> err 1 and rdata 0:
  - SH @0x11 -> word unchanged.
  - LW @0x02.
  - LW @4*DEPTH.
  - Load funct3=011.
  - Store funct3=100 -> memory unchanged.
- Backpressure: hold rsp_ready=0 for 3 cycles after an LW -> rsp_valid stays 1, rdata stable, req_ready=0; rsp_ready=1 with a new request -> accepted the same cycle.
- Reset mid-response: assert reset while rsp_valid=1 -> rsp_valid=0 asynchronously; init_done=0; CLEAR restarts, so previously stored 0xDEADBEEF reads 0 afterwards.

Source files
------------

// File: rtl/data_memory_lsu.sv
// Byte-addressable RV32 data memory with valid/ready load/store handshake.
// Registered response, fault reporting, and a zero-fill sweep after reset.
module data_memory_lsu #(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_clr_ptr;
  logic [31:0]     r_mem [DEPTH];
  logic [31:0]     r_rdata;
  logic            r_err;
  logic            r_init_done;

  logic [AW-1:0]   w_idx;
  logic [1:0]      w_lane;
  logic            w_oor;
  logic            w_illegal;
  logic            w_mis;
  logic            w_err;
  logic            w_accept;
  logic            w_wr;
  logic            w_clr_we;
  logic            w_clr_last;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load;

  assign w_idx      = req_addr[AW+1:2];
  assign w_lane     = req_addr[1:0];
  assign w_oor      = |req_addr[ADDR_W-1:AW+2];
  assign w_mis      = ((req_funct3[1:0] == 2'b01) & w_lane[0])
                    | ((req_funct3[1:0] == 2'b10) & (w_lane != 2'b00));
  assign w_err      = w_oor | w_illegal | w_mis;
  assign req_ready  = (r_state == S_IDLE)
                    | ((r_state == S_RESP) & rsp_ready);
  assign w_accept   = req_valid & req_ready;
  assign w_wr       = w_accept & req_we & ~w_err;
  assign w_clr_we   = (r_state == S_CLEAR) && (CLEAR_ON_RESET != 0);
  assign w_clr_last = (r_clr_ptr == AW'(DEPTH - 1));
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;
  assign init_done  = r_init_done;

  // Legal funct3 codes depend on access direction
  always_comb begin
    w_illegal = 1'b1;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
      3'b100, 3'b101:         w_illegal = req_we;
      default:                w_illegal = 1'b1;
    endcase
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_lane;
        w_wdata = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
      end
      default: w_be = 4'b0000;
    endcase
  end

  // Lane select and sign/zero extension of the addressed word
  always_comb begin
    w_word = r_mem[w_idx];
    w_byte = w_word[{w_lane, 3'b000} +: 8];
    w_half = w_word[{w_lane[1], 4'b0000} +: 16];
    w_load = '0;
    case (req_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = '0;
    endcase
  end

  // Memory array: clear sweep or byte-enabled store
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CLEAR: begin
        if (CLEAR_ON_RESET == 0 || w_clr_last) w_next = S_IDLE;
      end
      S_IDLE: begin
        if (w_accept) w_next = S_RESP;
      end
      S_RESP: begin
        if (w_accept)       w_next = S_RESP;
        else if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_CLEAR;
    endcase
  end

  // State, clear pointer, init flag and registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_clr_ptr   <= '0;
      r_init_done <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + AW'(1);
        if (w_next == S_IDLE) r_init_done <= 1'b1;
      end
      if (w_accept) begin
        r_err   <= w_err;
        r_rdata <= (w_err | req_we) ? 32'h0 : w_load;
      end
    end
  end
endmodule

// File: tb/tb_data_memory_lsu.sv
// Randomized plus directed bench for data_memory_lsu.
// Expected responses come from a byte-array model of the memory.
module tb_data_memory_lsu;
  localparam int DEPTH = 8;
  localparam int NB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m [NB];

  data_memory_lsu #(
    .DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NB; i++) m[i] = 8'h00;
  endfunction

  function automatic void model(input logic we,
                                input logic [31:0] a,
                                input logic [2:0] f3,
                                input logic [31:0] wd,
                                output logic e,
                                output logic [31:0] r);
    int sz;
    logic legal;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    if (we) legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
    else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2)
                 || (f3 == 4) || (f3 == 5);
    e = !legal || (a >= NB) || ((a % sz) != 0);
    r = 32'h0;
    if (e) return;
    if (we) begin
      for (int i = 0; i < sz; i++) m[a+i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v = v | (32'(m[a+i]) << (8*i));
      if (!f3[2] && sz < 4 && v[8*sz-1])
        v = v | (32'hFFFF_FFFF << (8*sz));
      r = v;
    end
  endfunction

  task automatic idle();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  // Issue at a negedge, check the response at the next negedge.
  task automatic send(input logic we, input logic [31:0] a,
                      input logic [2:0] f3, input logic [31:0] wd);
    logic e;
    logic [31:0] r;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_funct3 = f3;
    req_wdata  = wd;
    rsp_ready  = 1'b1;
    #1;
    check("req_ready", 32'(req_ready), 32'd1);
    model(we, a, f3, wd, e, r);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_err", 32'(rsp_err), 32'(e));
    check("rsp_rdata", rsp_rdata, r);
  endtask

  initial begin
    logic [31:0] held;
    logic        e;
    logic [31:0] r;
    int          k;

    #2;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      check("clr_init_done", 32'(init_done), 32'(i == DEPTH));
      check("clr_req_ready", 32'(req_ready), 32'(i == DEPTH));
    end

    send(1'b0, 32'h1C, 3'b010, 32'h0);
    send(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF);
    send(1'b0, 32'h10, 3'b010, 32'h0);
    check("lw_const", rsp_rdata, 32'hDEAD_BEEF);
    send(1'b0, 32'h13, 3'b000, 32'h0);
    check("lb_const", rsp_rdata, 32'hFFFF_FFDE);
    send(1'b0, 32'h13, 3'b100, 32'h0);
    send(1'b0, 32'h12, 3'b001, 32'h0);
    check("lh_const", rsp_rdata, 32'hFFFF_DEAD);
    send(1'b0, 32'h10, 3'b101, 32'h0);
    send(1'b1, 32'h11, 3'b000, 32'h55);
    send(1'b0, 32'h10, 3'b010, 32'h0);
    check("sb_const", rsp_rdata, 32'hDEAD_55EF);
    send(1'b1, 32'h11, 3'b001, 32'h1234);
    send(1'b0, 32'h10, 3'b010, 32'h0);
    send(1'b0, 32'h02, 3'b010, 32'h0);
    send(1'b0, 32'(NB), 3'b010, 32'h0);
    send(1'b0, 32'h10, 3'b011, 32'h0);
    send(1'b1, 32'h10, 3'b100, 32'hFFFF_FFFF);
    send(1'b0, 32'h10, 3'b010, 32'h0);
    check("fault_keep", rsp_rdata, 32'hDEAD_55EF);

    idle();
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h10;
    req_funct3 = 3'b010;
    rsp_ready  = 1'b0;
    #1;
    check("bp_req_ready", 32'(req_ready), 32'd1);
    model(1'b0, 32'h10, 3'b010, 32'h0, e, held);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, held);
      check("bp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    send(1'b0, 32'h13, 3'b000, 32'h0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) idle();
      send(1'($urandom_range(0, 1)),
           32'($urandom_range(0, NB + 5)),
           3'($urandom_range(0, 7)),
           $urandom);
    end

    send(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF);
    idle();
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h10;
    req_funct3 = 3'b010;
    rsp_ready  = 1'b0;
    model(1'b0, 32'h10, 3'b010, 32'h0, e, r);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mr_valid", 32'(rsp_valid), 32'd1);
    check("mr_rdata", rsp_rdata, r);
    #2;
    reset = 1'b1;
    #1;
    check("mr_valid_drop", 32'(rsp_valid), 32'd0);
    check("mr_init_done", 32'(init_done), 32'd0);
    check("mr_rdata_zero", rsp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    model_clear();
    k = 0;
    while (!init_done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mr_clear_cycles", 32'(k), 32'(DEPTH));
    send(1'b0, 32'h10, 3'b010, 32'h0);
    check("mr_cleared", rsp_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
